ifu_fetch: RTL and testbench

Instruction fetch unit, the transmitting end of the IFU→IDU valid/ready handshake in the 5-stage pipeline.
- Holds the architectural fetch PC and issues single-beat reads on an AXI4-Lite-style read channel (AR/R).
- Presents {inst, pc, num} to the IDU and advances sequentially.
- Redirects to branch_target_pc when control_hazard is raised, discarding wrong-path fetches.

---
 rtl/ifu_fetch_if.sv | 33 +++
 rtl/ifu_fetch.sv | 103 ++++++++++
 tb/tb_ifu_fetch.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-side bus bundle: AR/R read channel to instruction memory, IFU->IDU
// valid/ready handoff, redirect request and fetch error pulse.
//   master : instruction fetch unit
//   slave  : memory + decode/execute side
interface ifu_fetch_if #(
  parameter int unsigned NUM_W = 64
) ();
  logic [31:0]      araddr;
  logic             arvalid;
  logic             arready;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;
  logic             ifu_valid;
  logic             ifu_ready;
  logic [31:0]      inst;
  logic [31:0]      ifu_to_idu_pc;
  logic [NUM_W-1:0] num;
  logic             control_hazard;
  logic [31:0]      branch_target_pc;
  logic             fetch_err;

  modport master (
    output araddr, arvalid, rready, ifu_valid, inst, ifu_to_idu_pc, num, fetch_err,
    input  arready, rdata, rresp, rvalid, ifu_ready, control_hazard, branch_target_pc
  );

  modport slave (
    input  araddr, arvalid, rready, ifu_valid, inst, ifu_to_idu_pc, num, fetch_err,
    output arready, rdata, rresp, rvalid, ifu_ready, control_hazard, branch_target_pc
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the fetch PC, issues one single-beat read at a
// time on AR/R, hands {inst, pc, num} to the IDU and redirects on
// control_hazard, discarding wrong-path responses.
// Ports:
//   clock  - system clock
//   reset  - asynchronous active-low reset
//   bus    - ifu_fetch_if master: AR/R channel, IDU handoff, redirect, fetch_err
module ifu_fetch #(
  parameter logic [31:0]  RESET_PC = 32'h3000_0000,
  parameter int unsigned  NUM_W    = 64
) (
  input  logic        clock,
  input  logic        reset,
  ifu_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t           state_q;
  logic [31:0]      pc_q;
  logic [31:0]      target_q;
  logic             flush_q;
  logic [NUM_W-1:0] cnt_q;     // instructions delivered so far
  logic [NUM_W-1:0] num_q;     // number presented with the held instruction
  logic [31:0]      inst_q;
  logic [31:0]      out_pc_q;
  logic             err_q;

  // Fetch sequencer; AR is only ever accepted in REQ, so at most one read is outstanding.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
      flush_q  <= 1'b0;
      cnt_q    <= '0;
      num_q    <= '0;
      inst_q   <= '0;
      out_pc_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_BOOT: state_q <= S_REQ;
        S_REQ: begin
          // AR must stay stable, so a redirect here is only remembered.
          if (bus.control_hazard) begin
            target_q <= bus.branch_target_pc;
            flush_q  <= 1'b1;
          end
          if (bus.arready) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.control_hazard) begin
            target_q <= bus.branch_target_pc;
            flush_q  <= 1'b1;
          end
          if (bus.rvalid) begin
            if (flush_q || bus.control_hazard) begin
              // Wrong-path beat: drop it and restart at the latest target.
              flush_q <= 1'b0;
              pc_q    <= bus.control_hazard ? bus.branch_target_pc : target_q;
              state_q <= S_REQ;
            end else begin
              inst_q   <= bus.rdata;
              out_pc_q <= pc_q;
              num_q    <= cnt_q + NUM_W'(1);
              err_q    <= |bus.rresp;
              state_q  <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Redirect masks ifu_valid, so it always wins over ifu_ready.
          if (bus.control_hazard) begin
            pc_q    <= bus.branch_target_pc;
            state_q <= S_REQ;
          end else if (bus.ifu_ready) begin
            pc_q    <= 32'(pc_q + 32'd4);
            cnt_q   <= cnt_q + NUM_W'(1);
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_BOOT;
      endcase
    end
  end

  assign bus.araddr        = pc_q;
  assign bus.arvalid       = (state_q == S_REQ);
  assign bus.rready        = (state_q == S_WAIT);
  assign bus.ifu_valid     = (state_q == S_HOLD) && !bus.control_hazard;
  assign bus.inst          = inst_q;
  assign bus.ifu_to_idu_pc = out_pc_q;
  assign bus.num           = num_q;
  assign bus.fetch_err     = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a small instruction-memory model
// (AR accepted after ar_delay cycles, R beat two edges after acceptance).
module tb_ifu_fetch;

  logic clock;
  logic reset;

  ifu_fetch_if #(.NUM_W(64)) bus ();

  ifu_fetch #(.RESET_PC(32'h3000_0000), .NUM_W(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model
  int          ar_delay;
  int          ar_cnt;
  logic        busy;
  logic        stage;
  logic [31:0] maddr;
  logic [31:0] err_addr;

  assign bus.arready = bus.arvalid && !busy && (ar_cnt >= ar_delay);
  assign bus.rdata   = 32'h0000_0013;
  assign bus.rresp   = (maddr == err_addr) ? 2'b10 : 2'b00;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b0;
      stage      <= 1'b0;
      bus.rvalid <= 1'b0;
      ar_cnt     <= 0;
      maddr      <= 32'h0;
    end else begin
      if (bus.arvalid && bus.arready) begin
        busy   <= 1'b1;
        stage  <= 1'b1;
        maddr  <= bus.araddr;
        ar_cnt <= 0;
      end else if (bus.arvalid) begin
        ar_cnt <= ar_cnt + 1;
      end else begin
        ar_cnt <= 0;
      end
      if (stage) begin
        stage      <= 1'b0;
        bus.rvalid <= 1'b1;
      end
      if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
        busy       <= 1'b0;
      end
    end
  end

  // Monitors, sampled mid-cycle
  logic [31:0] dlv_pc[$];
  logic [63:0] dlv_num[$];
  logic [31:0] dlv_inst[$];
  int          err_cycles  = 0;
  int          bad_valid   = 0;
  int          ar_unstable = 0;
  logic        prev_pend   = 1'b0;
  logic [31:0] prev_addr   = 32'h0;

  always @(negedge clock) begin
    if (!reset) begin
      prev_pend = 1'b0;
    end else begin
      if (bus.ifu_valid && bus.ifu_ready) begin
        dlv_pc.push_back(bus.ifu_to_idu_pc);
        dlv_num.push_back(bus.num);
        dlv_inst.push_back(bus.inst);
      end
      if (bus.fetch_err) err_cycles++;
      if (bus.ifu_valid && bus.ifu_to_idu_pc == 32'h3000_000C) bad_valid++;
      if (prev_pend && (!bus.arvalid || bus.araddr != prev_addr)) ar_unstable++;
      prev_pend = bus.arvalid && !bus.arready;
      prev_addr = bus.araddr;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ar(input string tag);
    int n = 0;
    while (!(bus.arvalid && bus.arready) && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) check_vec({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.ifu_valid && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) check_vec({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic wait_dlv(input string tag, input int k);
    int n = 0;
    while (dlv_pc.size() < k && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check_vec({tag, "_timeout"}, 64'(dlv_pc.size()), 64'(k));
  endtask

  initial begin
    int          n;
    int          chg;
    logic [31:0] h_pc;
    logic [63:0] h_num;
    logic [31:0] h_inst;

    reset                = 1'b0;
    bus.ifu_ready        = 1'b1;
    bus.control_hazard   = 1'b0;
    bus.branch_target_pc = 32'h0;
    ar_delay             = 0;
    err_addr             = 32'hFFFF_FFFF;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check_vec("rst_arvalid",   64'(bus.arvalid),   64'd0);
    check_vec("rst_rready",    64'(bus.rready),    64'd0);
    check_vec("rst_ifu_valid", 64'(bus.ifu_valid), 64'd0);
    check_vec("rst_fetch_err", 64'(bus.fetch_err), 64'd0);
    check_vec("rst_num",       bus.num,            64'd0);
    check_vec("rst_inst",      64'(bus.inst),      64'd0);

    // Boot fetch and AR-to-valid latency
    @(negedge clock) reset = 1'b1;
    tick();
    check_vec("boot_arvalid", 64'(bus.arvalid), 64'd1);
    check_vec("boot_araddr",  64'(bus.araddr),  64'h3000_0000);
    n = 0;
    while (!bus.ifu_valid && n < 20) begin
      tick();
      n++;
    end
    check_vec("ar_to_valid_cycles", 64'(n), 64'd3);

    // Redirect in HOLD at 0x30000008, in the same cycle as ifu_ready
    wait_dlv("a_dlv2", 2);
    bus.ifu_ready = 1'b0;
    wait_valid("a_hold8");
    check_vec("a_hold8_pc", 64'(bus.ifu_to_idu_pc), 64'h3000_0008);
    bus.control_hazard   = 1'b1;
    bus.branch_target_pc = 32'h3000_0100;
    bus.ifu_ready        = 1'b1;
    #1;
    check_vec("hz_hold_mask", 64'(bus.ifu_valid), 64'd0);
    tick();
    bus.control_hazard = 1'b0;
    bus.ifu_ready      = 1'b0;
    check_vec("hz_hold_arvalid", 64'(bus.arvalid), 64'd1);
    check_vec("hz_hold_araddr",  64'(bus.araddr),  64'h3000_0100);

    // IDU stalls 5 cycles in HOLD
    wait_valid("a_hold100");
    h_pc   = bus.ifu_to_idu_pc;
    h_num  = bus.num;
    h_inst = bus.inst;
    check_vec("stall_pc",  64'(h_pc), 64'h3000_0100);
    check_vec("stall_num", h_num,     64'd3);
    chg = 0;
    repeat (5) begin
      tick();
      if (bus.ifu_to_idu_pc !== h_pc || bus.num !== h_num || bus.inst !== h_inst ||
          !bus.ifu_valid || bus.arvalid) chg++;
    end
    check_vec("stall_stable", 64'(chg), 64'd0);
    bus.ifu_ready = 1'b1;
    tick();
    wait_ar("a_ar104");
    check_vec("stall_next_araddr", 64'(bus.araddr), 64'h3000_0104);

    check_vec("a_dlv_count", 64'(dlv_pc.size()), 64'd3);
    if (dlv_pc.size() >= 3) begin
      check_vec("a_dlv0_pc",   64'(dlv_pc[0]),   64'h3000_0000);
      check_vec("a_dlv0_num",  dlv_num[0],       64'd1);
      check_vec("a_dlv0_inst", 64'(dlv_inst[0]), 64'h0000_0013);
      check_vec("a_dlv1_pc",   64'(dlv_pc[1]),   64'h3000_0004);
      check_vec("a_dlv1_num",  dlv_num[1],       64'd2);
      check_vec("a_dlv2_pc",   64'(dlv_pc[2]),   64'h3000_0100);
      check_vec("a_dlv2_num",  dlv_num[2],       64'd3);
    end

    // Reset asserted while a read is outstanding
    tick();
    check_vec("mid_rready_pre", 64'(bus.rready), 64'd1);
    reset = 1'b0;
    #1;
    check_vec("mid_rst_rready",  64'(bus.rready),  64'd0);
    check_vec("mid_rst_arvalid", 64'(bus.arvalid), 64'd0);
    check_vec("mid_rst_num",     bus.num,          64'd0);
    check_vec("mid_rst_inst",    64'(bus.inst),    64'd0);
    dlv_pc.delete();
    dlv_num.delete();
    dlv_inst.delete();
    @(negedge clock) reset = 1'b1;
    tick();

    // Sequential fetches 0,4,8 then redirect during a slow AR for 0x3000000C
    wait_dlv("b_dlv2", 2);
    wait_valid("b_hold8");
    ar_delay = 3;
    tick();
    check_vec("b_req_araddr",  64'(bus.araddr),  64'h3000_000C);
    check_vec("b_req_arready", 64'(bus.arready), 64'd0);
    tick();
    bus.control_hazard   = 1'b1;
    bus.branch_target_pc = 32'h3000_0200;
    tick();
    bus.control_hazard = 1'b0;
    check_vec("b_req_hold_arvalid", 64'(bus.arvalid), 64'd1);
    check_vec("b_req_hold_araddr",  64'(bus.araddr),  64'h3000_000C);
    wait_ar("b_arC");
    check_vec("b_acc_araddr", 64'(bus.araddr), 64'h3000_000C);
    ar_delay = 0;
    tick();
    wait_ar("b_ar200");
    check_vec("b_redir_araddr", 64'(bus.araddr), 64'h3000_0200);
    wait_dlv("b_dlv4", 4);
    check_vec("b_no_valid_C", 64'(bad_valid), 64'd0);
    if (dlv_pc.size() >= 4) begin
      check_vec("b_dlv2_pc",  64'(dlv_pc[2]), 64'h3000_0008);
      check_vec("b_dlv2_num", dlv_num[2],     64'd3);
      check_vec("b_dlv3_pc",  64'(dlv_pc[3]), 64'h3000_0200);
      check_vec("b_dlv3_num", dlv_num[3],     64'd4);
    end

    // Two redirects in WAIT, beat arriving with the second
    wait_ar("c_ar204");
    check_vec("c_araddr", 64'(bus.araddr), 64'h3000_0204);
    tick();
    check_vec("c_w1_rvalid", 64'(bus.rvalid), 64'd0);
    bus.control_hazard   = 1'b1;
    bus.branch_target_pc = 32'h3000_0040;
    tick();
    check_vec("c_w2_rvalid", 64'(bus.rvalid), 64'd1);
    bus.branch_target_pc = 32'h3000_0080;
    tick();
    bus.control_hazard = 1'b0;
    check_vec("c_next_arvalid", 64'(bus.arvalid), 64'd1);
    check_vec("c_next_araddr",  64'(bus.araddr),  64'h3000_0080);
    wait_dlv("c_dlv5", 5);
    if (dlv_pc.size() >= 5) begin
      check_vec("c_dlv4_pc",  64'(dlv_pc[4]), 64'h3000_0080);
      check_vec("c_dlv4_num", dlv_num[4],     64'd5);
    end

    // Error response on 0x30000010, reached by a redirect out of HOLD
    err_addr      = 32'h3000_0010;
    bus.ifu_ready = 1'b0;
    wait_valid("d_hold84");
    check_vec("d_hold84_pc", 64'(bus.ifu_to_idu_pc), 64'h3000_0084);
    bus.control_hazard   = 1'b1;
    bus.branch_target_pc = 32'h3000_0010;
    bus.ifu_ready        = 1'b1;
    tick();
    bus.control_hazard = 1'b0;
    wait_dlv("d_dlv6", 6);
    repeat (3) tick();
    check_vec("d_err_cycles", 64'(err_cycles), 64'd1);
    if (dlv_pc.size() >= 6) begin
      check_vec("d_dlv5_pc",   64'(dlv_pc[5]),   64'h3000_0010);
      check_vec("d_dlv5_num",  dlv_num[5],       64'd6);
      check_vec("d_dlv5_inst", 64'(dlv_inst[5]), 64'h0000_0013);
    end
    check_vec("ar_stable", 64'(ar_unstable), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
